rr_arbiter_4: RTL and testbench
===============================

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 8: maximum consecutive cycles one requester may hold the grant (legal range 1..256).
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 4: request per requester, bit i = requester i.
REQ-005 The block SHALL have port release, input, 1: the current grant holder finishes; ignored when no grant is active.
REQ-006 The block SHALL have port grant, output, 4: one-hot grant, registered.
REQ-007 The block SHALL have port grant_id, output, 2: binary index of the granted requester, registered.
REQ-008 The block SHALL have port grant_valid, output, 1: high while any grant is active.
REQ-009 The block SHALL have port timeout, output, 1: one-cycle pulse when a grant is revoked by the HOLD_MAX limit.

Function
REQ-010 The block SHALL implement two states: IDLE (no grant) and BUSY (one grant held).
REQ-011 The block SHALL keep grant equal to the 2-to-4 one-hot decode of grant_id whenever grant_valid=1, and grant=4'b0000 whenever grant_valid=0.
REQ-012 In IDLE with req!=0 at a rising edge, the block SHALL move to BUSY at that edge, granting the first set req bit searched upward from pointer ptr, modulo 4.
REQ-013 In IDLE with req=0, the block SHALL remain in IDLE with all outputs low.
REQ-014 Grant latency SHALL be one cycle: a req sampled at edge N produces grant visible after edge N.
REQ-015 In BUSY, the block SHALL increment a hold counter each cycle, starting at 0 on the granting edge.
REQ-016 In BUSY, the block SHALL leave to IDLE at the edge where any of these holds:
- release=1
- req[grant_id]=0
- hold counter = HOLD_MAX-1
REQ-017 On leaving BUSY, the block SHALL clear grant, grant_valid and grant_id, and set ptr = grant_id+1, wrapping 3 -> 0.
REQ-018 The block SHALL insert exactly one IDLE cycle between consecutive grants, including back-to-back grants to different requesters.
REQ-019 The block SHALL pulse timeout for one cycle, coincident with the IDLE cycle, only when exit is caused by the hold limit and neither release=1 nor req[grant_id]=0 at that edge.
REQ-020 When release and the hold limit coincide, the block SHALL treat the exit as a normal release, with no timeout pulse.
REQ-021 With HOLD_MAX=1, every grant SHALL last exactly one cycle.
REQ-022 Changes on req bits other than grant_id SHALL NOT affect BUSY.
REQ-023 The hold counter width SHALL be clog2(HOLD_MAX), minimum 1 bit, and SHALL never wrap.
REQ-024 The block SHALL ensure fairness: a continuously asserted request is granted within 4 grant periods.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force:
- state IDLE
- ptr=0
- hold counter 0
- grant=0000, grant_id=00, grant_valid=0, timeout=0
REQ-026 Reset asserted mid-grant SHALL drop the grant asynchronously.
REQ-027 After rst_n deasserts, the first grant SHALL be issued from ptr=0.

Verification
REQ-028 The bench SHALL cover single request: after reset, req=0100 held, release pulsed 3 cycles later -> grant=0100, grant_id=10 one cycle after req; IDLE for one cycle after release; then re-grant 0100.
REQ-029 The bench SHALL cover all-request rotation: req=1111 held, release pulsed each BUSY cycle -> grant sequence 0001, 0010, 0100, 1000, 0001 (wrap), with each grant separated by one IDLE cycle.
REQ-030 The bench SHALL cover timeout: HOLD_MAX=8, req=0010 held, no release -> grant 0010 for exactly 8 cycles, then timeout=1 for one cycle with grant=0000, then re-grant 0010.
REQ-031 The bench SHALL cover release coinciding with the limit: release asserted on the 8th BUSY cycle -> exit to IDLE, timeout stays 0.
REQ-032 The bench SHALL cover request withdrawal: holder 1000 drops req[3] while req=0011 -> IDLE one cycle, then grant 0001 (ptr wrapped to 0).
REQ-033 The bench SHALL cover reset mid-grant: rst_n=0 between clock edges during BUSY -> outputs 0 immediately; after release with req=1100 -> first grant 0100 (search from ptr=0).

Source files
------------

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with one-cycle grant latency, a mandatory idle
// cycle between grants and a per-grant hold limit that revokes stuck holders.
module rr_arbiter_4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    // "release" is a reserved SystemVerilog keyword, hence the longer name
    input  logic       release_grant,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [3:0]       grant_nxt;
    logic [1:0]       grant_id_nxt;
    logic             timeout_nxt;

    logic             exit_release;
    logic             exit_withdraw;
    logic             exit_limit;

    // First set request bit searching upward from p, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign exit_release  = release_grant;
    assign exit_withdraw = ~req[grant_id];
    assign exit_limit    = (hold_cnt == CNT_LAST);

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        grant_nxt    = grant;
        grant_id_nxt = grant_id;
        timeout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_nxt    = BUSY;
                    grant_id_nxt = rr_pick(req, ptr);
                    grant_nxt    = 4'b0001 << rr_pick(req, ptr);
                    hold_cnt_nxt = '0;
                end
            end
            BUSY: begin
                if (exit_release || exit_withdraw || exit_limit) begin
                    state_nxt    = IDLE;
                    ptr_nxt      = grant_id + 2'd1;
                    hold_cnt_nxt = '0;
                    grant_nxt    = 4'b0000;
                    grant_id_nxt = 2'd0;
                    // A limit hit only counts as a timeout when nothing else ended the grant
                    timeout_nxt  = exit_limit && !exit_release && !exit_withdraw;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            hold_cnt <= '0;
            grant    <= 4'b0000;
            grant_id <= 2'd0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            grant    <= grant_nxt;
            grant_id <= grant_id_nxt;
            timeout  <= timeout_nxt;
        end
    end

    assign grant_valid = (state == BUSY);

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: default HOLD_MAX=8 instance plus a HOLD_MAX=1 instance.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       rel;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    logic [3:0] req1;
    logic       rel1;
    logic [3:0] grant1;
    logic [1:0] grant_id1;
    logic       grant_valid1;
    logic       timeout1;

    int checks = 0;
    int errors = 0;

    logic [7:0] obs;
    logic [7:0] exp;

    rr_arbiter_4 #(.HOLD_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .release_grant(rel),
        .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid), .timeout(timeout)
    );

    rr_arbiter_4 #(.HOLD_MAX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .release_grant(rel1),
        .grant(grant1), .grant_id(grant_id1), .grant_valid(grant_valid1), .timeout(timeout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected encodings are {grant_valid, grant_id, grant, timeout}
    localparam logic [7:0] IDLE0 = 8'b0_00_0000_0;
    localparam logic [7:0] IDLE_TO = 8'b0_00_0000_1;
    localparam logic [7:0] G0 = 8'b1_00_0001_0;
    localparam logic [7:0] G1 = 8'b1_01_0010_0;
    localparam logic [7:0] G2 = 8'b1_10_0100_0;
    localparam logic [7:0] G3 = 8'b1_11_1000_0;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        #3;
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("FAIL reset_async obs=%b exp=%b", obs, IDLE0);
        end
        obs = {grant_valid1, grant_id1, grant1, timeout1};
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("FAIL reset_async_h1 obs=%b exp=%b", obs, IDLE0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("FAIL idle_no_req obs=%b exp=%b", obs, IDLE0);
        end
    endtask

    task automatic test_single;
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            obs = {grant_valid, grant_id, grant, timeout};
            checks++;
            if (obs !== G2) begin
                errors++;
                $display("FAIL single_grant cyc=%0d obs=%b exp=%b", c, obs, G2);
            end
        end
        rel = 1'b1;
        tick();
        rel = 1'b0;
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("FAIL single_idle obs=%b exp=%b", obs, IDLE0);
        end
        tick();
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== G2) begin
            errors++;
            $display("FAIL single_regrant obs=%b exp=%b", obs, G2);
        end
        req = 4'b0000;
        tick();
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("FAIL single_drop obs=%b exp=%b", obs, IDLE0);
        end
    endtask

    task automatic test_rotation;
        logic [7:0] seq [9];
        seq = '{G0, IDLE0, G1, IDLE0, G2, IDLE0, G3, IDLE0, G0};
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req = 4'b1111;
        rel = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            obs = {grant_valid, grant_id, grant, timeout};
            checks++;
            if (obs !== seq[c]) begin
                errors++;
                $display("FAIL rotation step=%0d obs=%b exp=%b", c, obs, seq[c]);
            end
        end
        req = 4'b0000;
        rel = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        req = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            tick();
            obs = {grant_valid, grant_id, grant, timeout};
            checks++;
            if (obs !== G1) begin
                errors++;
                $display("FAIL timeout_hold cyc=%0d obs=%b exp=%b", c, obs, G1);
            end
        end
        tick();
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== IDLE_TO) begin
            errors++;
            $display("FAIL timeout_pulse obs=%b exp=%b", obs, IDLE_TO);
        end
        tick();
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== G1) begin
            errors++;
            $display("FAIL timeout_regrant obs=%b exp=%b", obs, G1);
        end
    endtask

    // Continues the grant started at the end of test_timeout (BUSY cycle 1 already seen).
    task automatic test_release_at_limit;
        for (int c = 2; c <= 8; c++) begin
            tick();
            obs = {grant_valid, grant_id, grant, timeout};
            checks++;
            if (obs !== G1) begin
                errors++;
                $display("FAIL rel_limit_hold cyc=%0d obs=%b exp=%b", c, obs, G1);
            end
        end
        rel = 1'b1;
        tick();
        rel = 1'b0;
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("FAIL rel_limit_no_timeout obs=%b exp=%b", obs, IDLE0);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_withdraw;
        req = 4'b1000;
        tick();
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== G3) begin
            errors++;
            $display("FAIL withdraw_hold obs=%b exp=%b", obs, G3);
        end
        req = 4'b0011;
        tick();
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("FAIL withdraw_idle obs=%b exp=%b", obs, IDLE0);
        end
        tick();
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== G0) begin
            errors++;
            $display("FAIL withdraw_wrap obs=%b exp=%b", obs, G0);
        end
        // Other requesters toggling must not disturb the current holder
        req = 4'b1101;
        tick();
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== G0) begin
            errors++;
            $display("FAIL others_toggle_a obs=%b exp=%b", obs, G0);
        end
        req = 4'b0001;
        tick();
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== G0) begin
            errors++;
            $display("FAIL others_toggle_b obs=%b exp=%b", obs, G0);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid;
        req = 4'b1000;
        tick();
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== G3) begin
            errors++;
            $display("FAIL midrst_grant obs=%b exp=%b", obs, G3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("FAIL midrst_drop obs=%b exp=%b", obs, IDLE0);
        end
        req = 4'b1100;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        obs = {grant_valid, grant_id, grant, timeout};
        checks++;
        if (obs !== G2) begin
            errors++;
            $display("FAIL midrst_ptr0 obs=%b exp=%b", obs, G2);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_hold1;
        req1 = 4'b0001;
        tick();
        obs = {grant_valid1, grant_id1, grant1, timeout1};
        checks++;
        if (obs !== G0) begin
            errors++;
            $display("FAIL h1_grant obs=%b exp=%b", obs, G0);
        end
        tick();
        obs = {grant_valid1, grant_id1, grant1, timeout1};
        checks++;
        if (obs !== IDLE_TO) begin
            errors++;
            $display("FAIL h1_timeout obs=%b exp=%b", obs, IDLE_TO);
        end
        tick();
        obs = {grant_valid1, grant_id1, grant1, timeout1};
        checks++;
        if (obs !== G0) begin
            errors++;
            $display("FAIL h1_regrant obs=%b exp=%b", obs, G0);
        end
        rel1 = 1'b1;
        tick();
        rel1 = 1'b0;
        req1 = 4'b0000;
        obs = {grant_valid1, grant_id1, grant1, timeout1};
        checks++;
        if (obs !== IDLE0) begin
            errors++;
            $display("FAIL h1_release_limit obs=%b exp=%b", obs, IDLE0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        rel   = 1'b0;
        req1  = 4'b0000;
        rel1  = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_release_at_limit();
        test_withdraw();
        test_reset_mid();
        test_hold1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
